instr_encoder: RTL
==================

# instr_encoder

Pipelined RV32I instruction encoder, the inverse of `type_decoder`. It accepts a one-hot instruction-type select plus operand fields and produces a 32-bit RV32I instruction word through a 2-stage valid/ready pipeline. Test-stimulus generators and the boot-ROM builder use it to feed correctly formatted words toward fetch/decode. It flags malformed requests instead of emitting garbage.

## Interface
- `CNT_W`, 16: width of the accepted-instruction counter.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `in_type`  in  9  one-hot select. Bit order [8:0]: uj_type, u_type_lui, u_type_auipc, sb_type, s_type, i_type_jalr, i_type_addi, i_type_lw, r_type.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  funct3 field.
- `in_funct7`  in  7  funct7 field (R-type only).
- `in_imm`  in  32  immediate (sign-extended value, or U-type value with [11:0] ignored).
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  32  encoded instruction.
- `out_err`  out  1  word accompanies an error (qualified by `out_valid`).
- `instr_count`  out  CNT_W  count of accepted requests, saturating at all-ones.

## Operation
- Opcodes per type: r 0x33, lw 0x03, addi 0x13, jalr 0x67, s 0x23, sb 0x63, auipc 0x17, lui 0x37, uj 0x6F.
- Formats:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I (lw/addi/jalr): {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - UJ: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Unused fields are ignored, never OR'd in.
- Stage 1 registers the request. Stage 2 registers the formatted word and the error flag.
- Error cases:
  - `in_type` zero or not one-hot: `out_instr` = 0x00000013 (NOP), `out_err` = 1.
  - SB/UJ with imm[0] = 1: word is encoded with bit 0 dropped, `out_err` = 1.
  - Immediate out of the format's signed range: not checked; the value is truncated.
- `instr_count` increments on every accepted request, erroneous ones included. It saturates and does not wrap.

## Timing
- Accept when `in_valid && in_ready`. Emit when `out_valid && out_ready`.
- `in_ready = !s1_valid || s1_move`, where `s1_move = !s2_valid || out_ready`. It is combinational and has no dependency on `in_valid`.
- Latency: a request accepted at edge N appears on `out_valid`/`out_instr` after edge N+1. Minimum latency is 2 cycles from presenting the request.
- Throughput: 1 word/cycle while `out_ready` is held high.
- Backpressure: with `out_ready` low, stage 2 holds its word. Stage 1 fills and then `in_ready` drops, so at most 2 words are in flight. `out_instr`/`out_err` are stable while `out_valid && !out_ready`.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Simultaneous accept and emit with both stages full: both stages advance in the same edge and the new request enters stage 1.
- Reset values: `out_valid` = 0, `out_instr` = 0, `out_err` = 0, `instr_count` = 0, both stage valid bits = 0. `in_ready` = 1 during and after reset.
- Reset mid-operation discards in-flight words. No output appears after reset for pre-reset requests.

## Test plan
- R add x1,x2,x3 (funct7 0, funct3 0) -> `out_instr` 0x003100B3 two cycles later, `out_err` 0.
- addi x5,x0,-1 (imm 0xFFFFFFFF) -> 0xFFF00293. sw x2,8(x1) (funct3 2) -> 0x0020A423. lui x10 imm 0x12345000 -> 0x12345537.
- beq x0,x0 imm -4 -> 0xFE000EE3. jal x1 imm 0x800 -> 0x001000EF. jal imm 0x801 -> 0x001000EF with `out_err` 1.
- `in_type` 0 and `in_type` 0x003 -> 0x00000013 with `out_err` 1 each; `instr_count` still increments.
- Back-to-back stream of 5 requests with `out_ready` low for 4 cycles:
  - `in_ready` falls after 2 accepts.
  - The held word is stable.
  - All 5 words are emitted in order once `out_ready` rises; no loss.
- Assert `rst` with 2 words in flight -> next cycle `out_valid` 0, `instr_count` 0, `in_ready` 1; a new request encodes normally.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one-hot type select plus operand fields in, 32-bit word out,
// through a two-stage valid/ready pipeline with a saturating accepted-request counter.
module instr_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [8:0]       in_type,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [6:0] OpR     = 7'h33;
   localparam logic [6:0] OpLw    = 7'h03;
   localparam logic [6:0] OpAddi  = 7'h13;
   localparam logic [6:0] OpJalr  = 7'h67;
   localparam logic [6:0] OpS     = 7'h23;
   localparam logic [6:0] OpSb    = 7'h63;
   localparam logic [6:0] OpAuipc = 7'h17;
   localparam logic [6:0] OpLui   = 7'h37;
   localparam logic [6:0] OpUj    = 7'h6F;
   localparam logic [31:0] Nop    = 32'h0000_0013;

   logic             s1_valid_q;
   logic [8:0]       s1_type_q;
   logic [4:0]       s1_rd_q;
   logic [4:0]       s1_rs1_q;
   logic [4:0]       s1_rs2_q;
   logic [2:0]       s1_funct3_q;
   logic [6:0]       s1_funct7_q;
   logic [31:0]      s1_imm_q;
   logic             s2_valid_q;
   logic [31:0]      out_instr_q;
   logic             out_err_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic        s1_move;
   logic        accept;
   logic [31:0] enc_instr;
   logic        enc_err;

   assign s1_move     = !s2_valid_q || out_ready;
   assign in_ready    = !s1_valid_q || s1_move;
   assign accept      = in_valid && in_ready;
   assign out_valid   = s2_valid_q;
   assign out_instr   = out_instr_q;
   assign out_err     = out_err_q;
   assign instr_count = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (accept && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Anything that is not exactly one-hot falls to the default and becomes a flagged NOP.
   always_comb begin
      enc_instr = Nop;
      enc_err   = 1'b0;
      case (s1_type_q)
         9'b0_0000_0001: enc_instr = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, OpR};
         9'b0_0000_0010: enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, OpLw};
         9'b0_0000_0100: enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, OpAddi};
         9'b0_0000_1000: enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, OpJalr};
         9'b0_0001_0000: enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                      s1_imm_q[4:0], OpS};
         9'b0_0010_0000: begin
            enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                         s1_imm_q[4:1], s1_imm_q[11], OpSb};
            enc_err   = s1_imm_q[0];
         end
         9'b0_0100_0000: enc_instr = {s1_imm_q[31:12], s1_rd_q, OpAuipc};
         9'b0_1000_0000: enc_instr = {s1_imm_q[31:12], s1_rd_q, OpLui};
         9'b1_0000_0000: begin
            enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                         s1_rd_q, OpUj};
            enc_err   = s1_imm_q[0];
         end
         default: enc_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_instr_q <= 32'h0;
         out_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
         end
         if (s1_move) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_instr_q <= enc_instr;
               out_err_q   <= enc_err;
            end
         end
         cnt_q <= cnt_d;
      end
   end

   // Payload needs no reset; it is qualified by s1_valid_q.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_type_q   <= in_type;
         s1_rd_q     <= in_rd;
         s1_rs1_q    <= in_rs1;
         s1_rs2_q    <= in_rs2;
         s1_funct3_q <= in_funct3;
         s1_funct7_q <= in_funct7;
         s1_imm_q    <= in_imm;
      end
   end

endmodule
